// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader: word geometry,
// checksum width and the FSM state encoding.
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;
  localparam int CSUM_W         = 8;

  // FSM encoding; ST_CHK is only reachable when the checksum build is enabled.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RECV  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_CHK   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/imem_word_assembler.sv
// Packs a stream of bytes into big-endian 32-bit words. o_word is the
// completed word in the same cycle as the final byte, so the owner can
// capture it on the transfer edge.
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_en,
  input  logic [7:0]        i_byte,
  output logic              o_word_valid,
  output logic [WORD_W-1:0] o_word
);

  localparam int CNT_BITS = $clog2(BYTES_PER_WORD);
  localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(BYTES_PER_WORD - 1);

  logic [CNT_BITS-1:0] r_cnt;
  // Only the three earlier bytes need storing; the fourth arrives live.
  logic [WORD_W-9:0]   r_shift;

  assign o_word       = {r_shift, i_byte};
  assign o_word_valid = i_en && (r_cnt == LAST_IDX);

  // Byte counter and shift register; clear drops any partial word.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (i_en) begin
      r_cnt   <= (r_cnt == LAST_IDX) ? '0 : r_cnt + 1'b1;
      r_shift <= o_word[WORD_W-9:0];
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a program as bytes, packs them into
// 32-bit words and writes them to consecutive iMEM word addresses from 0,
// holding the CPU while the load runs.
// Optional trailer checksum: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_DEPTH = 32,
  parameter int CNT_W     = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_num_words,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte_data,
  output logic              o_byte_ready,
  output logic              o_wr_en,
  output logic [WORD_W-1:0] o_wr_addr,
  output logic [WORD_W-1:0] o_wr_data,
  output logic              o_cpu_hold,
  output logic              o_busy,
  output logic              o_done
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic              o_error
`endif
);

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_n_eff;
  logic [CNT_W-1:0]  r_widx;
  logic              r_hold;
  logic              r_wr_en;
  logic [WORD_W-1:0] r_wr_addr;
  logic [WORD_W-1:0] r_wr_data;

  logic              w_start_ok;
  logic              w_xfer;
  logic              w_asm_en;
  logic              w_word_valid;
  logic [WORD_W-1:0] w_word;
  logic [CNT_W-1:0]  w_n_eff;
  logic [CNT_W-1:0]  w_widx_inc;
  logic              w_last_word;

  assign w_start_ok  = (r_state == ST_IDLE) && i_start;
  // The load length is clamped so the word index can never leave the memory.
  assign w_n_eff     = (i_num_words > CNT_W'(MEM_DEPTH)) ? CNT_W'(MEM_DEPTH) : i_num_words;
  assign w_widx_inc  = r_widx + 1'b1;
  assign w_last_word = (w_widx_inc == r_n_eff);

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign o_byte_ready = (r_state == ST_RECV) || (r_state == ST_CHK);
`else
  assign o_byte_ready = (r_state == ST_RECV);
`endif
  assign w_xfer   = i_byte_valid && o_byte_ready;
  // Only payload bytes feed the assembler; the checksum trailer does not.
  assign w_asm_en = w_xfer && (r_state == ST_RECV);

  assign o_busy     = (r_state != ST_IDLE);
  assign o_done     = (r_state == ST_DONE);
  assign o_cpu_hold = r_hold;
  assign o_wr_en    = r_wr_en;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = r_wr_data;

  imem_word_assembler u_asm (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (w_start_ok),
    .i_en         (w_asm_en),
    .i_byte       (i_byte_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  // Load sequencing: IDLE -> RECV <-> WRITE -> (CHK) -> DONE -> IDLE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_n_eff <= '0;
      r_widx  <= '0;
      r_hold  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_n_eff <= w_n_eff;
            r_widx  <= '0;
            r_hold  <= 1'b1;
            r_state <= (w_n_eff == '0) ? ST_DONE : ST_RECV;
          end
        end
        ST_RECV: begin
          if (w_word_valid) r_state <= ST_WRITE;
        end
        ST_WRITE: begin
          r_widx <= w_widx_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
          r_state <= w_last_word ? ST_CHK : ST_RECV;
`else
          r_state <= w_last_word ? ST_DONE : ST_RECV;
`endif
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (w_xfer) r_state <= ST_DONE;
        end
`endif
        ST_DONE: begin
          r_hold  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Write port: word and address captured on the 4th byte, strobed next cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_word_valid;
      if (w_word_valid) begin
        r_wr_addr <= {{(WORD_W-CNT_W){1'b0}}, r_widx};
        r_wr_data <= w_word;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [CSUM_W-1:0] r_csum;
  logic              r_error;
  logic [CSUM_W-1:0] w_csum_final;

  assign w_csum_final = r_csum + i_byte_data;
  assign o_error      = r_error;

  // Running byte sum; the trailer must bring it to zero modulo 256.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_start_ok) begin
      r_csum  <= '0;
      r_error <= 1'b0;
    end else if (w_asm_en) begin
      r_csum <= w_csum_final;
    end else if (w_xfer && (r_state == ST_CHK)) begin
      if (w_csum_final != '0) r_error <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes are queued with the
// stimulus and popped by a monitor whenever the DUT strobes o_wr_en.
module tb_imem_loader;

  localparam int MEM_DEPTH = 32;
  localparam int CNT_W     = 6;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_start;
  logic [CNT_W-1:0] i_num_words;
  logic             i_byte_valid;
  logic [7:0]       i_byte_data;
  logic             o_byte_ready;
  logic             o_wr_en;
  logic [31:0]      o_wr_addr;
  logic [31:0]      o_wr_data;
  logic             o_cpu_hold;
  logic             o_busy;
  logic             o_done;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic             o_error;
`endif

  imem_loader #(.MEM_DEPTH(MEM_DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_num_words  (i_num_words),
    .i_byte_valid (i_byte_valid),
    .i_byte_data  (i_byte_data),
    .o_byte_ready (o_byte_ready),
    .o_wr_en      (o_wr_en),
    .o_wr_addr    (o_wr_addr),
    .o_wr_data    (o_wr_data),
    .o_cpu_hold   (o_cpu_hold),
    .o_busy       (o_busy),
    .o_done       (o_done)
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    .o_error      (o_error)
`endif
  );

  always #5 i_clk = ~i_clk;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          wr_cnt   = 0;
  int          last_wr_cyc = -1;
  int          start_cyc   = 0;
  int          done_cyc    = -1;
  bit          done_seen;
  logic [63:0] exp_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  csum = 8'h00;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: each write strobe pops and compares one expected word.
  always @(negedge i_clk) begin
    logic [63:0] e;
    if (o_wr_en === 1'b1) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      $display("tb: write addr=%0d data=0x%08h cyc=%0d", o_wr_addr, o_wr_data, cyc);
      checks++;
      assert (o_byte_ready === 1'b0) else begin
        failures++;
        $error("FAIL wr_ready observed=%0b expected=0", o_byte_ready);
      end
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL wr_unexpected observed_addr=%0d expected=no_write", o_wr_addr);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        assert (o_wr_addr === e[63:32]) else begin
          failures++;
          $error("FAIL wr_addr observed=%0d expected=%0d", o_wr_addr, e[63:32]);
        end
        checks++;
        assert (o_wr_data === e[31:0]) else begin
          failures++;
          $error("FAIL wr_data observed=0x%08h expected=0x%08h", o_wr_data, e[31:0]);
        end
      end
    end
  end

  // Queue one word: expected write plus its four big-endian bytes.
  task automatic queue_word(input logic [31:0] addr, input logic [31:0] w);
    exp_q.push_back({addr, w});
    for (int b = 3; b >= 0; b--) begin
      tx_q.push_back(w[b*8 +: 8]);
      csum = csum + w[b*8 +: 8];
    end
  endtask

  // Closing checksum byte when the trailer feature is built in.
  task automatic queue_trailer();
`ifdef IMEM_LOADER_CHECKSUM_EN
    tx_q.push_back(8'h00 - csum);
`endif
    csum = 8'h00;
  endtask

  // Pulse i_start for one edge; called and returns on a falling edge.
  task automatic do_start(input logic [CNT_W-1:0] n);
    i_num_words = n;
    i_start     = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_start   = 1'b0;
    start_cyc = cyc;
    $display("tb: start n=%0d cyc=%0d", n, cyc);
    check("hold_after_start", {31'b0, o_cpu_hold}, 32'd1);
    check("busy_after_start", {31'b0, o_busy}, 32'd1);
  endtask

  // Byte source: drains tx_q, optionally every other cycle, and either waits
  // for o_done or stops once the queue is empty. start_at injects a stray
  // i_start pulse on that iteration.
  task automatic run_load(input bit bp, input bit wait_done, input int start_at, input int budget);
    int  n = 0;
    bit  rdy;
    done_seen = 1'b0;
    while ((wait_done ? !done_seen : (tx_q.size() > 0)) && n < budget) begin
      if (wait_done && o_done === 1'b1) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
      end else begin
        i_start      = (n == start_at);
        i_num_words  = 6'd5;
        i_byte_valid = (tx_q.size() > 0) && (!bp || n[0] == 1'b0);
        i_byte_data  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
        rdy          = o_byte_ready;
        @(posedge i_clk);
        if (i_byte_valid && rdy) void'(tx_q.pop_front());
        @(negedge i_clk);
        n++;
      end
    end
    i_start      = 1'b0;
    i_byte_valid = 1'b0;
    if (wait_done) check("done_within_budget", {31'b0, done_seen}, 32'd1);
    else           check("bytes_within_budget", tx_q.size(), 32'd0);
  endtask

  // Post-load checks: hold still high in DONE, everything consumed, then idle.
  task automatic finish_load(input string tag);
    $display("tb: %s done cyc=%0d writes_total=%0d", tag, done_cyc, wr_cnt);
    check({tag, "_hold_in_done"}, {31'b0, o_cpu_hold}, 32'd1);
    check({tag, "_tx_empty"}, tx_q.size(), 32'd0);
    check({tag, "_exp_empty"}, exp_q.size(), 32'd0);
    @(negedge i_clk);
    check({tag, "_hold_released"}, {31'b0, o_cpu_hold}, 32'd0);
    check({tag, "_idle"}, {31'b0, o_busy}, 32'd0);
    check({tag, "_done_one_cycle"}, {31'b0, o_done}, 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, {31'b0, o_busy}, 32'd0);
    check({tag, "_hold"}, {31'b0, o_cpu_hold}, 32'd0);
    check({tag, "_done"}, {31'b0, o_done}, 32'd0);
    check({tag, "_ready"}, {31'b0, o_byte_ready}, 32'd0);
    check({tag, "_wr_en"}, {31'b0, o_wr_en}, 32'd0);
    check({tag, "_wr_addr"}, o_wr_addr, 32'd0);
    check({tag, "_wr_data"}, o_wr_data, 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check({tag, "_error"}, {31'b0, o_error}, 32'd0);
`endif
  endtask

  initial begin
    int w0;
    i_rst = 1'b1; i_start = 1'b0; i_num_words = '0;
    i_byte_valid = 1'b0; i_byte_data = 8'h00;
    repeat (3) @(negedge i_clk);
    check_outputs_zero("reset");
    i_rst = 1'b0;
    @(negedge i_clk);

    // Basic two-word load with an always-valid source.
    w0 = wr_cnt;
    queue_word(32'd0, 32'h3C081001);
    queue_word(32'd1, 32'h00000008);
    queue_trailer();
    do_start(6'd2);
    run_load(1'b0, 1'b1, -1, 100);
`ifndef IMEM_LOADER_CHECKSUM_EN
    check("basic_done_after_last_write", done_cyc, last_wr_cyc + 1);
`endif
    check("basic_write_count", wr_cnt - w0, 32'd2);
    finish_load("basic");

    // Same stream under backpressure.
    w0 = wr_cnt;
    queue_word(32'd0, 32'h3C081001);
    queue_word(32'd1, 32'h00000008);
    queue_trailer();
    do_start(6'd2);
    run_load(1'b1, 1'b1, -1, 200);
    check("bp_write_count", wr_cnt - w0, 32'd2);
    finish_load("bp");

    // Zero-length load: DONE in the cycle right after the start edge.
    w0 = wr_cnt;
    do_start(6'd0);
    run_load(1'b0, 1'b1, -1, 10);
    check("zero_done_cycle", done_cyc, start_cyc);
    check("zero_write_count", wr_cnt - w0, 32'd0);
    finish_load("zero");

    // Over-length request is clamped to the memory depth.
    w0 = wr_cnt;
    for (int i = 0; i < MEM_DEPTH; i++) queue_word(i, $urandom);
    queue_trailer();
    do_start(6'd40);
    run_load(1'b0, 1'b1, -1, 400);
    check("over_write_count", wr_cnt - w0, MEM_DEPTH);
    finish_load("over");

    // Reset after six bytes of a three-word load.
    w0 = wr_cnt;
    queue_word(32'd0, 32'h11223344);
    tx_q.push_back(8'h55);
    tx_q.push_back(8'h66);
    do_start(6'd3);
    run_load(1'b0, 1'b0, -1, 50);
    check("rst_mid_write_count", wr_cnt - w0, 32'd1);
    check("rst_mid_exp_empty", exp_q.size(), 32'd0);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    csum = 8'h00;
    check_outputs_zero("rst_mid");
    w0 = wr_cnt;
    queue_word(32'd0, 32'hDEADBEEF);
    queue_trailer();
    do_start(6'd1);
    run_load(1'b0, 1'b1, -1, 50);
    check("after_rst_write_count", wr_cnt - w0, 32'd1);
    finish_load("after_rst");

    // Stray i_start while receiving must not restart or resize the load.
    w0 = wr_cnt;
    queue_word(32'd0, 32'hA5A50F0F);
    queue_word(32'd1, 32'h01234567);
    queue_trailer();
    do_start(6'd2);
    run_load(1'b0, 1'b1, 2, 100);
    check("stray_start_write_count", wr_cnt - w0, 32'd2);
    finish_load("stray_start");

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Trailer that zeroes the sum leaves o_error low.
    queue_word(32'd0, 32'h01020304);
    tx_q.push_back(8'hF6);
    csum = 8'h00;
    do_start(6'd1);
    run_load(1'b0, 1'b1, -1, 50);
    check("csum_good_error", {31'b0, o_error}, 32'd0);
    finish_load("csum_good");
    // Wrong trailer flags an error that survives until the next start.
    queue_word(32'd0, 32'h01020304);
    tx_q.push_back(8'hF7);
    csum = 8'h00;
    do_start(6'd1);
    run_load(1'b0, 1'b1, -1, 50);
    check("csum_bad_error", {31'b0, o_error}, 32'd1);
    finish_load("csum_bad");
    check("csum_bad_error_held", {31'b0, o_error}, 32'd1);
    do_start(6'd0);
    check("csum_error_cleared", {31'b0, o_error}, 32'd0);
    run_load(1'b0, 1'b1, -1, 10);
    finish_load("csum_clear");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
